// File: rtl/board_io_conditioner.sv
// Board input conditioner: per-channel synchroniser + debouncer, optional edge pulses, stretched reset.
// Define BOARD_IO_EDGE_EN to build the rise/fall edge registers; otherwise rise/fall are tied low.
module board_io_conditioner #(
  parameter int                  CHANNELS          = 4,
  parameter int                  SYNC_STAGES       = 2,
  parameter int                  DEBOUNCE_CYCLES   = 120000,
  parameter logic [CHANNELS-1:0] RESET_VALUE       = {CHANNELS{1'b0}},
  parameter int                  RESET_HOLD_CYCLES = 16,
  parameter int                  RESET_ON_CH0      = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in_raw,
  output logic [CHANNELS-1:0] stable,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                reset_out
);

  localparam int              CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam int              HW        = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RUN     = 2'd2
  } rst_state_e;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] stable_q, stable_d;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  rst_state_e          state_q, state_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                reset_out_q, reset_out_d;
  logic                ch0_req;

  always_comb begin
    sync_d[0] = in_raw;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Any cycle where the synchronised level matches the accepted one restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VALUE;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q <= RESET_VALUE;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

`ifdef BOARD_IO_EDGE_EN
  logic [CHANNELS-1:0] rise_q, rise_d, fall_q, fall_d;

  always_comb begin
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

  assign ch0_req = (RESET_ON_CH0 != 0) && stable_q[0];

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_HOLD: begin
        hold_cnt_d = '0;
        if (!ch0_req) state_d = ST_STRETCH;
      end
      ST_STRETCH: begin
        if (ch0_req) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (ch0_req) state_d = ST_HOLD;
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase
    // Registered from next state so reset_out tracks the FSM with no extra cycle.
    reset_out_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      reset_out_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      reset_out_q <= reset_out_d;
    end
  end

  assign reset_out = reset_out_q;

endmodule

// File: doc/board_io_conditioner.md
# board_io_conditioner

Parametrised board-level input conditioner placed between FPGA pins and `rvsteel_mcu` in board top-levels. It synchronises and debounces CHANNELS raw inputs (buttons, switches, GPIO inputs), produces clean levels and optional one-cycle edge pulses, and generates a stretched MCU reset. The reset can also be driven from a debounced reset-button channel. It replaces the single-flop reset register and ad-hoc button handling in each board wrapper.

## Interface
- CHANNELS, 4: number of conditioned inputs, ≥1.
- SYNC_STAGES, 2: synchroniser depth per channel, ≥2.
- DEBOUNCE_CYCLES, 120000: consecutive cycles a new level must persist before acceptance, ≥1 (10 ms at 12 MHz).
- RESET_VALUE, {CHANNELS{1'b0}}: reset value of synchronisers and `stable`.
- RESET_HOLD_CYCLES, 16: reset-stretch length, ≥1.
- RESET_ON_CH0, 1: 1 = channel 0 is a reset button feeding `reset_out`; 0 = ignored for reset.
- clock  input  1  single system clock.
- reset  input  1  asynchronous, active-high reset.
- in_raw  input  CHANNELS  raw asynchronous pin levels.
- stable  output  CHANNELS  debounced levels.
- rise  output  CHANNELS  one-cycle pulse when `stable[i]` goes 0→1.
- fall  output  CHANNELS  one-cycle pulse when `stable[i]` goes 1→0.
- reset_out  output  1  stretched active-high reset for downstream logic.

## Operation
- Reset values: sync chain and `stable` = RESET_VALUE; debounce counters 0; `rise`/`fall` 0; `reset_out` 1, reset FSM in HOLD, hold counter 0.
- Per channel: SYNC_STAGES-flop chain produces `s[i]`. Debounce counter width is $clog2(DEBOUNCE_CYCLES+1).
  - `s[i]==stable[i]`: counter cleared to 0, including for single-cycle glitches.
  - `s[i]!=stable[i]` and counter < DEBOUNCE_CYCLES-1: counter increments.
  - `s[i]!=stable[i]` and counter == DEBOUNCE_CYCLES-1: `stable[i]` <= `s[i]`, counter <= 0, and `rise[i]`/`fall[i]` asserted for exactly the first cycle `stable[i]` shows the new value.
- Channels are fully independent. Simultaneous transitions on several channels are all reported in the same cycle.
- Reset FSM:
  - HOLD: `reset_out`=1. Entered on async `reset` or, when RESET_ON_CH0=1, on any clock edge where `stable[0]==1`. Leaves to STRETCH on the first edge with `reset` low and (`stable[0]==0` or RESET_ON_CH0=0).
  - STRETCH: `reset_out`=1, hold counter increments each cycle. Returns to HOLD if `stable[0]==1` and RESET_ON_CH0=1, with the counter cleared. Goes to RUN when the counter reaches RESET_HOLD_CYCLES-1.
  - RUN: `reset_out`=0. Goes to HOLD on `stable[0]==1` with RESET_ON_CH0=1.
- `reset_out` asserts asynchronously with `reset` and deasserts only on a clock edge.
- Async `reset` mid-debounce or mid-stretch aborts the operation and restores all reset values. No edge pulse is generated at reset release.

## Timing
- `in_raw[i]` change, held steady and sampled at edge 1: `stable[i]` and the edge pulse are visible after edge SYNC_STAGES+DEBOUNCE_CYCLES. Defaults give 120002 cycles.
- DEBOUNCE_CYCLES=1: `stable` follows `s` with one cycle of delay.
- `reset` released before edge 1 with `stable[0]`=0: `reset_out` falls after edge RESET_HOLD_CYCLES+1. That is 1 edge HOLD→STRETCH, then RESET_HOLD_CYCLES edges in STRETCH.
- `stable[0]` rises at edge t, RESET_ON_CH0=1: `reset_out` is 1 after edge t+1. It falls RESET_HOLD_CYCLES+1 edges after the edge where `stable[0]` returns to 0.
- All outputs are registered. There is no combinational path from `in_raw` to any output.

## Configuration
- `BOARD_IO_EDGE_EN` defined: `rise`/`fall` registers and logic compiled in, as described above.
- `BOARD_IO_EDGE_EN` undefined: `rise`/`fall` are tied to 0 and no edge registers are built. The `stable` and `reset_out` behaviour is unchanged, and the ports remain present.

## Test plan
- All tests use CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=4, RESET_ON_CH0=1, `BOARD_IO_EDGE_EN` defined, unless stated.
- Release `reset` with `in_raw`=0 -> `reset_out` 1 through edge 4, 0 after edge 5; `stable`=0 and no `rise`/`fall` pulse at any point.
- `in_raw[1]` 0→1 held steady -> `stable[1]`=1 after edge 10; `rise[1]` high for exactly one cycle; `fall` stays 0.
- `in_raw[2]` toggles high for 7 cycles, low 1, high 8 -> no change on the first burst; `stable[2]` rises 10 edges after the final 0→1.
- `in_raw[0]` pressed for 20 cycles, then released -> `reset_out` rises 1 edge after `stable[0]` rises; it falls 5 edges after `stable[0]` falls.
- Async `reset` pulse while channel 3 counter=5 -> outputs take reset values immediately and the counter is 0. Repeat with `BOARD_IO_EDGE_EN` undefined -> `rise`/`fall` remain 0 throughout.
